// File: rtl/useq_ctrl.sv
// Microcode sequencer: writable control store plus opcode dispatch table, with
// conditional branch, wait, call/return stack and stall.
module useq_ctrl #(
  parameter int CTRL_W    = 46,
  parameter int S_W       = 8,
  parameter int N_COND    = 8,
  parameter int CS_W      = $clog2(N_COND) + 1,
  parameter int DEPTH     = 4,
  parameter int RESET_VEC = 0,
  parameter int UW        = CTRL_W + 1 + 3 + CS_W + 1 + S_W
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              stall,
  input  logic [7:0]        data_in,
  input  logic [N_COND-1:0] cond_in,
  input  logic              ucode_we,
  input  logic [S_W-1:0]    ucode_waddr,
  input  logic [UW-1:0]     ucode_wdata,
  input  logic              disp_we,
  input  logic [7:0]        disp_waddr,
  input  logic [S_W-1:0]    disp_wdata,
  output logic [CTRL_W-1:0] controls,
  output logic              last_cycle,
  output logic [S_W-1:0]    upc,
  output logic [7:0]        opcode,
  output logic              stack_err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [S_W-1:0] RV = S_W'(RESET_VEC);

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JUMP = 3'b001,
    OP_BR   = 3'b010,
    OP_DISP = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_WAIT = 3'b110,
    OP_RSVD = 3'b111
  } seq_op_t;

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  logic [UW-1:0]  store [0:(1<<S_W)-1];
  logic [S_W-1:0] disp  [0:255];
  logic [S_W-1:0] stk   [0:DEPTH-1];

  logic [UW-1:0]   uw_q;
  logic [SPW-1:0]  sp;
  state_t          state, state_nxt;

  seq_op_t         seq_op;
  logic [CS_W-1:0] cond_sel;
  logic            cond_pol;
  logic [S_W-1:0]  nxt_f;
  logic [S_W-1:0]  upc_inc;
  logic [S_W-1:0]  stk_top;
  logic [S_W-1:0]  nxt;
  logic            cond_raw, c;
  logic            push, pop, err_set, ld_op;

  assign controls   = uw_q[UW-1 -: CTRL_W];
  assign last_cycle = uw_q[UW-1-CTRL_W];
  assign seq_op     = seq_op_t'(uw_q[S_W+CS_W+3 : S_W+CS_W+1]);
  assign cond_sel   = uw_q[S_W+CS_W : S_W+1];
  assign cond_pol   = uw_q[S_W];
  assign nxt_f      = uw_q[S_W-1:0];
  assign upc_inc    = upc + S_W'(1);

  // Out-of-range selects read as constant true, so pol=1 there means "never".
  always_comb begin
    cond_raw = 1'b1;
    for (int i = 0; i < N_COND; i++)
      if (cond_sel == CS_W'(i)) cond_raw = cond_in[i];
  end
  assign c = cond_raw ^ cond_pol;

  always_comb begin
    stk_top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SPW'(i + 1)) stk_top = stk[i];
  end

  always_comb begin
    nxt     = upc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    ld_op   = 1'b0;
    case (seq_op)
      OP_JUMP: nxt = nxt_f;
      OP_BR:   nxt = c ? nxt_f : upc_inc;
      OP_DISP: begin
        nxt   = disp[data_in];
        ld_op = 1'b1;
      end
      OP_CALL: begin
        nxt = nxt_f;
        if (sp == SPW'(DEPTH)) err_set = 1'b1;
        else                   push    = 1'b1;
      end
      OP_RET: begin
        if (sp == '0) begin
          nxt     = RV;
          err_set = 1'b1;
        end else begin
          nxt = stk_top;
          pop = 1'b1;
        end
      end
      OP_WAIT: nxt = c ? nxt_f : upc;
      default: nxt = upc_inc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (!stall) state_nxt = ST_RUN;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Store and table are not reset; a same-edge fetch sees the old contents.
  always_ff @(posedge ph1) begin
    if (ucode_we) store[ucode_waddr] <= ucode_wdata;
    if (disp_we)  disp[disp_waddr]   <= disp_wdata;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      upc       <= RV;
      uw_q      <= '0;
      opcode    <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else if (!stall) begin
      if (state == ST_BOOT) begin
        uw_q <= store[RV];
      end else begin
        upc  <= nxt;
        uw_q <= store[nxt];
        if (ld_op)   opcode    <= data_in;
        if (err_set) stack_err <= 1'b1;
        if (push) begin
          sp <= sp + SPW'(1);
          for (int i = 0; i < DEPTH; i++)
            if (sp == SPW'(i)) stk[i] <= upc_inc;
        end
        if (pop) sp <= sp - SPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Self-checking bench for useq_ctrl: table-driven main program plus
// hand-written boot, stack, write-collision and async-reset sequences.
module tb_useq_ctrl;

  localparam int CTRL_W = 46;
  localparam int S_W    = 8;
  localparam int N_COND = 8;
  localparam int CS_W   = 4;
  localparam int UW     = CTRL_W + 1 + 3 + CS_W + 1 + S_W;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, DSP = 3'd3,
                         CAL = 3'd4, RET = 3'd5, WT = 3'd6, RSV = 3'd7;

  logic              ph1 = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [7:0]        data_in = '0;
  logic [N_COND-1:0] cond_in = '0;
  logic              ucode_we = 1'b0;
  logic [S_W-1:0]    ucode_waddr = '0;
  logic [UW-1:0]     ucode_wdata = '0;
  logic              disp_we = 1'b0;
  logic [7:0]        disp_waddr = '0;
  logic [S_W-1:0]    disp_wdata = '0;
  logic [CTRL_W-1:0] controls;
  logic              last_cycle;
  logic [S_W-1:0]    upc;
  logic [7:0]        opcode;
  logic              stack_err;

  int checks = 0;
  int errors = 0;

  useq_ctrl dut (
    .ph1(ph1), .reset(reset), .stall(stall), .data_in(data_in), .cond_in(cond_in),
    .ucode_we(ucode_we), .ucode_waddr(ucode_waddr), .ucode_wdata(ucode_wdata),
    .disp_we(disp_we), .disp_waddr(disp_waddr), .disp_wdata(disp_wdata),
    .controls(controls), .last_cycle(last_cycle), .upc(upc), .opcode(opcode),
    .stack_err(stack_err)
  );

  always #5 ph1 = ~ph1;

  typedef struct {
    logic [S_W-1:0]    upc;
    logic [CTRL_W-1:0] ctrl;
    logic              last;
    logic [7:0]        op;
    logic              err;
  } exp_t;

  typedef struct {
    logic              st;
    logic [7:0]        din;
    logic [N_COND-1:0] cnd;
    exp_t              e;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[20];

  function automatic logic [UW-1:0] mw(input logic [CTRL_W-1:0] cw, input logic l,
                                       input logic [2:0] op, input logic [CS_W-1:0] cs,
                                       input logic pol, input logic [S_W-1:0] nx);
    return {cw, l, op, cs, pol, nx};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic uwr(input logic [S_W-1:0] a, input logic [UW-1:0] d);
    ucode_we = 1'b1; ucode_waddr = a; ucode_wdata = d;
    @(posedge ph1); #1;
    ucode_we = 1'b0;
  endtask

  task automatic dwr(input logic [7:0] a, input logic [S_W-1:0] d);
    disp_we = 1'b1; disp_waddr = a; disp_wdata = d;
    @(posedge ph1); #1;
    disp_we = 1'b0;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".controls"}, 64'(controls), 64'd0);
    chk({tag, ".last"},     64'(last_cycle), 64'd0);
    chk({tag, ".upc"},      64'(upc), 64'd0);
    chk({tag, ".opcode"},   64'(opcode), 64'd0);
    chk({tag, ".err"},      64'(stack_err), 64'd0);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic st, input logic [7:0] din,
                      input logic [N_COND-1:0] cnd, input exp_t ex);
    exp_t e;
    stall = st; data_in = din; cond_in = cnd;
    sbq.push_back(ex);
    @(posedge ph1); #1;
    e = sbq.pop_front();
    chk({tag, ".upc"},      64'(upc), 64'(e.upc));
    chk({tag, ".controls"}, 64'(controls), 64'(e.ctrl));
    chk({tag, ".last"},     64'(last_cycle), 64'(e.last));
    chk({tag, ".opcode"},   64'(opcode), 64'(e.op));
    chk({tag, ".err"},      64'(stack_err), 64'(e.err));
  endtask

  task automatic go_reset();
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic stack_run(input string tag);
    logic [S_W-1:0] su [12];
    su = '{8'h00, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'h81, 8'h71, 8'h61, 8'h01, 8'h00, 8'h60};
    for (int i = 0; i < 12; i++)
      step($sformatf("%s[%0d]", tag, i), 1'b0, 8'h00, '0,
           '{su[i], CTRL_W'(12'h300) + CTRL_W'(su[i]), 1'b0, 8'h00, (i >= 5)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Boot
    @(posedge ph1); #1;
    rst_chk("reset0");
    uwr(8'h00, mw(46'h5, 0, INC, 0, 0, 8'h00));
    uwr(8'h01, mw(46'h9, 0, JMP, 0, 0, 8'h00));
    release_reset();
    step("boot0", 0, 0, 0, '{8'h00, 46'h5, 0, 8'h00, 0});
    step("boot1", 0, 0, 0, '{8'h01, 46'h9, 0, 8'h00, 0});
    step("boot2", 0, 0, 0, '{8'h00, 46'h5, 0, 8'h00, 0});
    step("boot3", 0, 0, 0, '{8'h01, 46'h9, 0, 8'h00, 0});

    // Main program: dispatch, branch, wait, stall, reserved op
    go_reset();
    uwr(8'h01, mw(46'h9,   0, DSP, 0, 0, 8'h00));
    uwr(8'h07, mw(46'hAB,  0, JMP, 0, 0, 8'h10));
    uwr(8'h10, mw(46'h110, 0, BR,  2, 0, 8'h42));
    uwr(8'h11, mw(46'h111, 0, JMP, 0, 0, 8'h20));
    uwr(8'h42, mw(46'h142, 0, JMP, 0, 0, 8'h20));
    uwr(8'h20, mw(46'h120, 0, BR,  8, 1, 8'h50));
    uwr(8'h21, mw(46'h121, 0, WT,  0, 0, 8'h30));
    uwr(8'h30, mw(46'h130, 0, RSV, 0, 0, 8'h77));
    uwr(8'h31, mw(46'h131, 1, INC, 0, 0, 8'h00));
    uwr(8'h32, mw(46'h132, 0, JMP, 0, 0, 8'h01));
    uwr(8'h50, mw(46'h150, 0, JMP, 0, 0, 8'h50));
    dwr(8'h69, 8'h07);
    dwr(8'h12, 8'h10);
    tbl[0]  = '{0, 8'h00, 8'h00, '{8'h00, 46'h5,   0, 8'h00, 0}};
    tbl[1]  = '{0, 8'h00, 8'h00, '{8'h01, 46'h9,   0, 8'h00, 0}};
    tbl[2]  = '{0, 8'h69, 8'h00, '{8'h07, 46'hAB,  0, 8'h69, 0}};
    tbl[3]  = '{0, 8'h00, 8'h00, '{8'h10, 46'h110, 0, 8'h69, 0}};
    tbl[4]  = '{0, 8'h00, 8'h04, '{8'h42, 46'h142, 0, 8'h69, 0}};
    tbl[5]  = '{0, 8'h00, 8'h00, '{8'h20, 46'h120, 0, 8'h69, 0}};
    tbl[6]  = '{0, 8'h00, 8'hFF, '{8'h21, 46'h121, 0, 8'h69, 0}};
    tbl[7]  = '{0, 8'h00, 8'h00, '{8'h21, 46'h121, 0, 8'h69, 0}};
    tbl[8]  = '{0, 8'h00, 8'hFE, '{8'h21, 46'h121, 0, 8'h69, 0}};
    tbl[9]  = '{1, 8'h00, 8'h01, '{8'h21, 46'h121, 0, 8'h69, 0}};
    tbl[10] = '{1, 8'h00, 8'h01, '{8'h21, 46'h121, 0, 8'h69, 0}};
    tbl[11] = '{1, 8'h00, 8'h01, '{8'h21, 46'h121, 0, 8'h69, 0}};
    tbl[12] = '{0, 8'h00, 8'h01, '{8'h30, 46'h130, 0, 8'h69, 0}};
    tbl[13] = '{0, 8'h00, 8'h00, '{8'h31, 46'h131, 1, 8'h69, 0}};
    tbl[14] = '{0, 8'h00, 8'h00, '{8'h32, 46'h132, 0, 8'h69, 0}};
    tbl[15] = '{0, 8'h00, 8'h00, '{8'h01, 46'h9,   0, 8'h69, 0}};
    tbl[16] = '{1, 8'h12, 8'h00, '{8'h01, 46'h9,   0, 8'h69, 0}};
    tbl[17] = '{0, 8'h12, 8'h00, '{8'h10, 46'h110, 0, 8'h12, 0}};
    tbl[18] = '{0, 8'h00, 8'h00, '{8'h11, 46'h111, 0, 8'h12, 0}};
    tbl[19] = '{0, 8'h00, 8'h00, '{8'h20, 46'h120, 0, 8'h12, 0}};
    release_reset();
    for (int i = 0; i < 20; i++)
      step($sformatf("main[%0d]", i), tbl[i].st, tbl[i].din, tbl[i].cnd, tbl[i].e);
    go_reset();
    rst_chk("async_main");

    // Stack: five nested calls on a depth-4 stack, then five returns
    uwr(8'h00, mw(46'h300, 0, CAL, 0, 0, 8'h60));
    uwr(8'h60, mw(46'h360, 0, CAL, 0, 0, 8'h70));
    uwr(8'h70, mw(46'h370, 0, CAL, 0, 0, 8'h80));
    uwr(8'h80, mw(46'h380, 0, CAL, 0, 0, 8'h90));
    uwr(8'h90, mw(46'h390, 0, CAL, 0, 0, 8'hA0));
    uwr(8'hA0, mw(46'h3A0, 0, RET, 0, 0, 8'h00));
    uwr(8'h81, mw(46'h381, 0, RET, 0, 0, 8'h00));
    uwr(8'h71, mw(46'h371, 0, RET, 0, 0, 8'h00));
    uwr(8'h61, mw(46'h361, 0, RET, 0, 0, 8'h00));
    uwr(8'h01, mw(46'h301, 0, RET, 0, 0, 8'h00));
    release_reset();
    stack_run("stk");
    go_reset();
    rst_chk("async_stack");
    release_reset();
    stack_run("stk2");
    go_reset();

    // Write collision on store[3]
    uwr(8'h00, mw(46'h400, 0, JMP, 0, 0, 8'h03));
    uwr(8'h03, mw(46'h333, 0, JMP, 0, 0, 8'h04));
    uwr(8'h04, mw(46'h444, 0, JMP, 0, 0, 8'h03));
    release_reset();
    step("coll0", 0, 0, 0, '{8'h00, 46'h400, 0, 8'h00, 0});
    ucode_we = 1'b1; ucode_waddr = 8'h03; ucode_wdata = mw(46'h3CC, 0, JMP, 0, 0, 8'h04);
    step("coll1", 0, 0, 0, '{8'h03, 46'h333, 0, 8'h00, 0});
    ucode_we = 1'b0;
    step("coll2", 0, 0, 0, '{8'h04, 46'h444, 0, 8'h00, 0});
    step("coll3", 0, 0, 0, '{8'h03, 46'h3CC, 0, 8'h00, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
